// File: rtl/alu_mc.sv
`default_nettype none
// ============================================================================
// Module   : alu_mc
// Purpose  : Multi-cycle execute-stage ALU. Single-cycle add/sub/logic/shift
//            ops, iterative unsigned shift-add multiply, valid/ready
//            handshake, registered result and {V,C,N,Z} condition codes.
// Revision : 1.0 - initial release
// ============================================================================
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [3:0]       i_op,
  input  logic [WIDTH-1:0] i_op1,
  input  logic [WIDTH-1:0] i_op2,
  input  logic             i_cc_we,
  input  logic             i_flush,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_result,
  output logic [3:0]       o_ccodes
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] c_OP_ADD = 4'd1;
  localparam logic [3:0] c_OP_SUB = 4'd2;
  localparam logic [3:0] c_OP_OR  = 4'd3;
  localparam logic [3:0] c_OP_AND = 4'd4;
  localparam logic [3:0] c_OP_NOT = 4'd5;
  localparam logic [3:0] c_OP_XOR = 4'd6;
  localparam logic [3:0] c_OP_SHL = 4'd7;
  localparam logic [3:0] c_OP_SHR = 4'd8;
  localparam logic [3:0] c_OP_SRA = 4'd9;
  localparam logic [3:0] c_OP_MUL = 4'd10;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  state_t             r_state;
  logic [SHW-1:0]     r_count;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic               r_cc_we;

  logic               w_accept;
  logic [SHW-1:0]     w_sh;
  logic [WIDTH:0]     w_ext;
  logic [WIDTH-1:0]   w_res;
  logic               w_c;
  logic               w_v;
  logic [3:0]         w_flags;
  logic [2*WIDTH-1:0] w_acc_next;
  logic [WIDTH-1:0]   w_prod_lo;
  logic               w_prod_hi_nz;

  assign o_ready  = (r_state == S_IDLE);
  assign w_accept = i_valid & o_ready & ~i_flush;
  assign w_sh     = i_op2[SHW-1:0];

  // Single-cycle datapath: result plus carry/overflow for the requested op.
  // Shifts run through a WIDTH+1 wide value so the extra bit catches the last
  // bit shifted out; a zero shift leaves that bit 0.
  always_comb begin
    w_ext = '0;
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (i_op)
      c_OP_ADD: begin
        w_ext = {1'b0, i_op1} + {1'b0, i_op2};
        w_res = w_ext[WIDTH-1:0];
        w_c   = w_ext[WIDTH];
        w_v   = (i_op1[WIDTH-1] == i_op2[WIDTH-1]) & (w_res[WIDTH-1] != i_op1[WIDTH-1]);
      end
      c_OP_SUB: begin
        w_ext = {1'b0, i_op1} - {1'b0, i_op2};
        w_res = w_ext[WIDTH-1:0];
        w_c   = w_ext[WIDTH];
        w_v   = (i_op1[WIDTH-1] != i_op2[WIDTH-1]) & (w_res[WIDTH-1] != i_op1[WIDTH-1]);
      end
      c_OP_OR:  w_res = i_op1 | i_op2;
      c_OP_AND: w_res = i_op1 & i_op2;
      c_OP_NOT: w_res = ~i_op1;
      c_OP_XOR: w_res = i_op1 ^ i_op2;
      c_OP_SHL: begin
        w_ext = {1'b0, i_op1} << w_sh;
        w_res = w_ext[WIDTH-1:0];
        w_c   = w_ext[WIDTH];
      end
      c_OP_SHR: begin
        w_ext = {i_op1, 1'b0} >> w_sh;
        w_res = w_ext[WIDTH:1];
        w_c   = w_ext[0];
      end
      c_OP_SRA: begin
        w_ext = $unsigned($signed({i_op1, 1'b0}) >>> w_sh);
        w_res = w_ext[WIDTH:1];
        w_c   = w_ext[0];
      end
      default: begin
        w_ext = '0;
        w_res = '0;
      end
    endcase
    w_flags = {w_v, w_c, w_res[WIDTH-1], (w_res == '0)};
  end

  // One shift-add multiply step; the final step's sum is the full product.
  always_comb begin
    w_acc_next   = r_acc + (r_mplier[0] ? r_mcand : '0);
    w_prod_lo    = w_acc_next[WIDTH-1:0];
    w_prod_hi_nz = |w_acc_next[2*WIDTH-1:WIDTH];
  end

  // Control FSM with registered result, flags and one-cycle valid pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cc_we  <= 1'b0;
      o_valid  <= 1'b0;
      o_result <= '0;
      o_ccodes <= '0;
    end else begin
      o_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (i_op == c_OP_MUL) begin
              r_state  <= S_MUL;
              r_count  <= '0;
              r_acc    <= '0;
              r_mcand  <= {{WIDTH{1'b0}}, i_op1};
              r_mplier <= i_op2;
              r_cc_we  <= i_cc_we;
            end else begin
              o_result <= w_res;
              o_valid  <= 1'b1;
              if (i_cc_we) o_ccodes <= w_flags;
            end
          end
        end
        S_MUL: begin
          if (i_flush) begin
            // Abort: drop the partial product, leave result/flags alone.
            r_state <= S_IDLE;
          end else begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_count  <= r_count + SHW'(1);
            if (r_count == SHW'(WIDTH - 1)) begin
              r_state  <= S_IDLE;
              o_result <= w_prod_lo;
              o_valid  <= 1'b1;
              if (r_cc_we)
                o_ccodes <= {w_prod_hi_nz, w_prod_hi_nz, w_prod_lo[WIDTH-1], (w_prod_lo == '0)};
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_mc
// Purpose  : Directed self-checking bench for alu_mc (WIDTH=32).
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_mc;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_valid;
  logic        o_ready;
  logic [3:0]  i_op;
  logic [31:0] i_op1;
  logic [31:0] i_op2;
  logic        i_cc_we;
  logic        i_flush;
  logic        o_valid;
  logic [31:0] o_result;
  logic [3:0]  o_ccodes;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [3:0] NOP = 4'd0, ADD = 4'd1, SUB = 4'd2, OR_ = 4'd3, AND_ = 4'd4;
  localparam logic [3:0] XOR_ = 4'd6, SHL = 4'd7, SHR = 4'd8, SRA = 4'd9, MUL = 4'd10;

  alu_mc #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_op     (i_op),
    .i_op1    (i_op1),
    .i_op2    (i_op2),
    .i_cc_we  (i_cc_we),
    .i_flush  (i_flush),
    .o_valid  (o_valid),
    .o_result (o_result),
    .o_ccodes (o_ccodes)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present one op for one cycle; returns just after the accepting edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic cc);
    i_valid = 1'b1;
    i_op    = op;
    i_op1   = a;
    i_op2   = b;
    i_cc_we = cc;
    tick();
    i_valid = 1'b0;
  endtask

  // Count cycles until o_valid, bounded.
  task automatic wait_valid(input int max, output int n);
    n = 0;
    while (!o_valid && n < max) begin
      tick();
      n++;
    end
  endtask

  // Count o_valid pulses over a window.
  task automatic count_valid(input int cycles, output int nv);
    nv = 0;
    for (int k = 0; k < cycles; k++) begin
      if (o_valid) nv++;
      tick();
    end
  endtask

  initial begin
    int n;
    int bad;

    reset   = 1'b1;
    i_valid = 1'b0;
    i_op    = NOP;
    i_op1   = '0;
    i_op2   = '0;
    i_cc_we = 1'b0;
    i_flush = 1'b0;
    repeat (3) tick();
    check("rst_valid",  {31'd0, o_valid}, 32'd0);
    check("rst_result", o_result, 32'd0);
    check("rst_cc",     {28'd0, o_ccodes}, 32'd0);
    check("rst_ready",  {31'd0, o_ready}, 32'd1);
    reset = 1'b0;
    tick();

    // ADD with carry out to zero
    issue(ADD, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
    check("add_valid",  {31'd0, o_valid}, 32'd1);
    check("add_result", o_result, 32'h0);
    check("add_cc",     {28'd0, o_ccodes}, 32'b0101);
    tick();
    check("add_pulse_end", {31'd0, o_valid}, 32'd0);

    // SUB signed overflow, then SUB with borrow
    issue(SUB, 32'h8000_0000, 32'h0000_0001, 1'b1);
    check("sub_ov_result", o_result, 32'h7FFF_FFFF);
    check("sub_ov_cc",     {28'd0, o_ccodes}, 32'b1000);
    issue(SUB, 32'd3, 32'd5, 1'b1);
    check("sub_bw_result", o_result, 32'hFFFF_FFFE);
    check("sub_bw_cc",     {28'd0, o_ccodes}, 32'b0110);

    // Shifts
    issue(SRA, 32'h8000_0001, 32'd1, 1'b1);
    check("sra_result", o_result, 32'hC000_0000);
    check("sra_cc",     {28'd0, o_ccodes}, 32'b0110);
    issue(SHL, 32'h1234_5678, 32'd0, 1'b1);
    check("shl0_result", o_result, 32'h1234_5678);
    check("shl0_cc",     {28'd0, o_ccodes}, 32'b0000);
    issue(SHR, 32'h0000_0003, 32'd1, 1'b1);
    check("shr_result", o_result, 32'h0000_0001);
    check("shr_cc",     {28'd0, o_ccodes}, 32'b0100);
    issue(SHL, 32'h8000_0001, 32'd33, 1'b1);
    check("shl_amt_result", o_result, 32'h0000_0002);
    check("shl_amt_cc",     {28'd0, o_ccodes}, 32'b0100);

    // XOR without flag update
    issue(XOR_, 32'hA5A5_A5A5, 32'hFFFF_FFFF, 1'b0);
    check("xor_result", o_result, 32'h5A5A_5A5A);
    check("xor_cc_hold", {28'd0, o_ccodes}, 32'b0100);

    // NOP with flag update
    issue(NOP, 32'h1111_1111, 32'h2222_2222, 1'b1);
    check("nop_valid",  {31'd0, o_valid}, 32'd1);
    check("nop_result", o_result, 32'h0);
    check("nop_cc",     {28'd0, o_ccodes}, 32'b0001);
    tick();

    // MUL overflowing into the high half; inputs are driven during busy
    issue(MUL, 32'h0001_0000, 32'h0001_0000, 1'b1);
    bad = 0;
    for (int k = 0; k < 32; k++) begin
      if (o_ready || o_valid) bad++;
      i_valid = 1'b1;
      i_op    = ADD;
      i_op1   = 32'd1;
      i_op2   = 32'd1;
      tick();
    end
    i_valid = 1'b0;
    check("mul_busy_cycles", bad, 0);
    check("mul_valid_at_33", {31'd0, o_valid}, 32'd1);
    check("mul_ready_back",  {31'd0, o_ready}, 32'd1);
    check("mul_ov_result",   o_result, 32'h0);
    check("mul_ov_cc",       {28'd0, o_ccodes}, 32'b1101);
    tick();

    // Small MUL
    issue(MUL, 32'd7, 32'd6, 1'b1);
    wait_valid(40, n);
    check("mul_small_latency", n, 32);
    check("mul_small_result",  o_result, 32'd42);
    check("mul_small_cc",      {28'd0, o_ccodes}, 32'b0000);
    tick();

    // Flush mid-MUL at cycle 10
    issue(SUB, 32'd3, 32'd5, 1'b1);
    tick();
    issue(MUL, 32'h0000_FFFF, 32'h0000_FFFF, 1'b1);
    repeat (9) tick();
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    check("flush_ready",  {31'd0, o_ready}, 32'd1);
    check("flush_valid",  {31'd0, o_valid}, 32'd0);
    check("flush_result", o_result, 32'hFFFF_FFFE);
    check("flush_cc",     {28'd0, o_ccodes}, 32'b0110);
    issue(ADD, 32'd2, 32'd3, 1'b1);
    check("post_flush_valid",  {31'd0, o_valid}, 32'd1);
    check("post_flush_result", o_result, 32'd5);
    check("post_flush_cc",     {28'd0, o_ccodes}, 32'b0000);
    tick();
    count_valid(40, n);
    check("flush_no_stray", n, 0);

    // Flush in IDLE blocks the accept
    i_flush = 1'b1;
    issue(ADD, 32'd9, 32'd9, 1'b1);
    i_flush = 1'b0;
    check("idle_flush_valid",  {31'd0, o_valid}, 32'd0);
    check("idle_flush_result", o_result, 32'd5);

    // Flush on the final MUL cycle
    issue(MUL, 32'd7, 32'd6, 1'b1);
    repeat (31) tick();
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    check("final_flush_valid",  {31'd0, o_valid}, 32'd0);
    check("final_flush_result", o_result, 32'd5);
    count_valid(5, n);
    check("final_flush_no_stray", n, 0);

    // Back-to-back single-cycle ops
    i_valid = 1'b1; i_cc_we = 1'b1;
    i_op = ADD;  i_op1 = 32'd1;  i_op2 = 32'd2;  tick();
    check("b2b_add_valid",  {31'd0, o_valid}, 32'd1);
    check("b2b_add_result", o_result, 32'd3);
    i_op = OR_;  i_op1 = 32'hF0; i_op2 = 32'h0F; tick();
    check("b2b_or_valid",   {31'd0, o_valid}, 32'd1);
    check("b2b_or_result",  o_result, 32'hFF);
    i_op = AND_; i_op1 = 32'hFF; i_op2 = 32'h3C; tick();
    i_valid = 1'b0;
    check("b2b_and_valid",  {31'd0, o_valid}, 32'd1);
    check("b2b_and_result", o_result, 32'h3C);
    tick();
    check("b2b_end", {31'd0, o_valid}, 32'd0);

    // Reset mid-MUL
    issue(MUL, 32'd7, 32'd6, 1'b1);
    repeat (5) tick();
    reset = 1'b1;
    tick();
    check("rmul_valid",  {31'd0, o_valid}, 32'd0);
    check("rmul_result", o_result, 32'd0);
    check("rmul_cc",     {28'd0, o_ccodes}, 32'd0);
    check("rmul_ready",  {31'd0, o_ready}, 32'd1);
    reset = 1'b0;
    count_valid(40, n);
    check("rmul_no_stray", n, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
